fetch_queue: RTL and testbench

//  Instruction fetch front end: generates word-indexed PCs (next = pc+1), issues requests to

---
 rtl/fetch_pkg.sv | 12 +
 rtl/sync_fifo.sv | 79 +++++++
 rtl/fetch_queue.sv | 137 +++++++++++++
 tb/tb_fetch_queue.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: types and constants shared by the fetch front end.
// Defines the prefetch queue entry layout {pc, instr} and the PC step.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] WORD_INC = 32'd1;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: in-order register FIFO with one-cycle flush.
// Ports: clk, rst (async, active-high), i_flush (clears pointers),
//   i_push/i_wdata (write), i_pop (read advance), o_rdata (head),
//   o_empty, o_count (occupancy, $clog2(DEPTH)+1 bits).
// Depth need not be a power of two; pointers wrap explicitly.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_wdata,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_rdata,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST) ? '0 : p + AW'(1);
    endfunction

    // A flush wins over any push or pop issued in the same cycle.
    assign w_pop  = i_pop & ~i_flush & (r_count != '0);
    assign w_push = i_push & ~i_flush
                  & ((r_count != CW'(DEPTH)) | w_pop);

    assign o_rdata = r_mem[r_rptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            if (w_push & ~w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop & ~w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end with in-order prefetch queue.
// Ports: clk, rst (async, active-high), enable, redirect_valid/redirect_pc,
//   imem_req/imem_addr/imem_gnt (request), imem_rvalid/imem_rdata (response),
//   out_valid/out_pc/out_instr/out_ready (handshake to decode).
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    input  logic        out_ready
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(MAX_OUTSTANDING) + 1;

    logic [31:0]   r_fetch_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop_cnt;

    logic [CW-1:0] w_q_count;
    logic [CW:0]   w_inflight;
    logic          w_credit;
    logic          w_issue;
    logic          w_ret;
    logic          w_drop_ret;
    logic          w_q_push;
    logic          w_q_pop;
    logic          w_q_empty;
    fetch_entry_t  w_q_wdata;
    fetch_entry_t  w_q_head;
    logic [31:0]   w_pend_pc;
    logic          w_pend_empty;
    logic [PW-1:0] w_pend_count;
    logic          w_unused_pend;

    // Every in-flight request reserves a queue slot, so a return
    // always has room even when decode is stalled.
    assign w_inflight = {1'b0, w_q_count} + {1'b0, r_outstanding};
    assign w_credit   = (w_inflight < (CW+1)'(DEPTH))
                      & (r_outstanding < CW'(MAX_OUTSTANDING));

    assign imem_req  = enable & ~redirect_valid & ~rst & w_credit;
    assign imem_addr = r_fetch_pc;

    assign w_issue    = imem_req & imem_gnt;
    assign w_ret      = imem_rvalid;
    assign w_drop_ret = w_ret & (r_drop_cnt != '0);

    // Push and pop are suppressed inside the queue on redirect.
    assign w_q_push  = w_ret & ~w_drop_ret;
    assign w_q_pop   = ~w_q_empty & out_ready;
    assign w_q_wdata = '{pc: w_pend_pc, instr: imem_rdata};

    assign out_valid = ~w_q_empty;
    assign out_pc    = w_q_head.pc;
    assign out_instr = w_q_head.instr;

    assign w_unused_pend = ^{w_pend_empty, w_pend_count};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_outstanding <= r_outstanding + CW'(w_issue)
                           - CW'(w_ret);
            if (redirect_valid) begin
                r_fetch_pc <= redirect_pc;
                // Everything still in flight after this cycle is stale.
                // Responses already marked for drop are part of that
                // set, so the result is the remaining in-flight count.
                r_drop_cnt <= r_outstanding - CW'(w_ret);
            end else begin
                if (w_issue) begin
                    r_fetch_pc <= r_fetch_pc + WORD_INC;
                end
                if (w_drop_ret) begin
                    r_drop_cnt <= r_drop_cnt - CW'(1);
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .i_flush (redirect_valid),
        .i_push  (w_q_push),
        .i_wdata (w_q_wdata),
        .i_pop   (w_q_pop),
        .o_rdata (w_q_head),
        .o_empty (w_q_empty),
        .o_count (w_q_count)
    );

    // Not flushed on redirect: stale responses still need their slot
    // popped so later PCs stay aligned with later responses.
    sync_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_OUTSTANDING)
    ) u_pending (
        .clk     (clk),
        .rst     (rst),
        .i_flush (1'b0),
        .i_push  (w_issue),
        .i_wdata (r_fetch_pc),
        .i_pop   (w_ret),
        .o_rdata (w_pend_pc),
        .o_empty (w_pend_empty),
        .o_count (w_pend_count)
    );

    a_no_stray_rvalid: assert property (
        @(posedge clk) disable iff (rst)
        imem_rvalid |-> (r_outstanding != '0)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: checks fetch_queue against an in-order memory model
// and a sequential-PC scoreboard (stream restarts at each redirect).
module tb_fetch_queue;

    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready = 1'b0;

    always #5 clk = ~clk;

    fetch_queue dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_ready      (out_ready)
    );

    typedef struct {
        logic [31:0] pc;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] log_q[$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          lat_lo = 1;
    int          lat_hi = 1;
    bit          gnt_rand = 1'b0;
    logic [31:0] exp_issue_pc = '0;
    logic [31:0] exp_out_pc = '0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic pick_gnt();
        return gnt_rand ? 1'($urandom_range(1, 0)) : 1'b1;
    endfunction

    // One clock: sample before the edge, update the models at the
    // edge, then drive the memory response for the next edge.
    task automatic tick();
        logic        s_req, s_gnt, s_rv, s_ov, s_rdy, s_redir, s_en;
        logic [31:0] s_addr, s_opc, s_oin, s_rpc;
        #1;
        s_req   = imem_req;
        s_gnt   = imem_gnt;
        s_rv    = imem_rvalid;
        s_ov    = out_valid;
        s_rdy   = out_ready;
        s_redir = redirect_valid;
        s_en    = enable;
        s_addr  = imem_addr;
        s_opc   = out_pc;
        s_oin   = out_instr;
        s_rpc   = redirect_pc;
        if (s_req) begin
            total++;
            if (s_redir || !s_en || mq.size() >= MAXO) begin
                bad++;
                $display("FAIL req_gating: imem_req=1 redirect=%0b enable=%0b inflight=%0d",
                         s_redir, s_en, mq.size());
            end
        end
        @(posedge clk);
        cyc++;
        if (s_req && s_gnt) begin
            total++;
            if (s_addr !== exp_issue_pc) begin
                bad++;
                $display("FAIL issue_addr: got %h want %h", s_addr, exp_issue_pc);
            end
            mq.push_back('{pc: s_addr,
                           due: cyc + int'($urandom_range(lat_hi, lat_lo))});
            exp_issue_pc = exp_issue_pc + 32'd1;
        end
        if (s_rv && mq.size() > 0) begin
            void'(mq.pop_front());
        end
        if (s_redir) begin
            exp_issue_pc = s_rpc;
            exp_out_pc   = s_rpc;
        end else if (s_ov && s_rdy) begin
            total++;
            if (s_opc !== exp_out_pc || s_oin !== memf(exp_out_pc)) begin
                bad++;
                $display("FAIL out_data: pc got %h want %h, instr got %h want %h",
                         s_opc, exp_out_pc, s_oin, memf(exp_out_pc));
            end
            log_q.push_back(s_opc);
            exp_out_pc = exp_out_pc + 32'd1;
        end
        @(negedge clk);
        imem_rvalid = 1'b0;
        if (mq.size() > 0) begin
            if (mq[0].due <= cyc + 1) begin
                imem_rvalid = 1'b1;
            end
        end
        imem_rdata = imem_rvalid ? memf(mq[0].pc) : $urandom();
        imem_gnt   = pick_gnt();
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        imem_rvalid    = 1'b0;
        imem_gnt       = 1'b0;
        redirect_valid = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || imem_req !== 1'b0 ||
            out_pc !== 32'd0 || out_instr !== 32'd0) begin
            bad++;
            $display("FAIL reset_outputs: valid=%b req=%b pc=%h instr=%h want 0 0 0 0",
                     out_valid, imem_req, out_pc, out_instr);
        end
        repeat (2) @(negedge clk);
        mq.delete();
        log_q.delete();
        exp_issue_pc = 32'd0;
        exp_out_pc   = 32'd0;
        rst          = 1'b0;
        imem_gnt     = pick_gnt();
    endtask

    task automatic test_reset();
        enable    = 1'b1;
        out_ready = 1'b1;
        lat_lo    = 1;
        lat_hi    = 1;
        gnt_rand  = 1'b0;
        @(negedge clk);
        do_reset();
        #1;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
            bad++;
            $display("FAIL first_req: req=%b addr=%h want 1 00000000",
                     imem_req, imem_addr);
        end
    endtask

    task automatic test_stream();
        repeat (6) tick();
        log_q.delete();
        repeat (10) tick();
        total++;
        if (log_q.size() != 10) begin
            bad++;
            $display("FAIL stream_rate: got %0d pops want 10", log_q.size());
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        enable    = 1'b1;
        do_reset();
        repeat (12) tick();
        #1;
        total++;
        if (imem_req !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'd0) begin
            bad++;
            $display("FAIL full_stall: req=%b valid=%b pc=%h want 0 1 00000000",
                     imem_req, out_valid, out_pc);
        end
        enable    = 1'b0;
        out_ready = 1'b1;
        log_q.delete();
        repeat (8) tick();
        total++;
        if (log_q.size() != 4) begin
            bad++;
            $display("FAIL full_depth: got %0d entries want 4", log_q.size());
        end
        enable = 1'b1;
        repeat (6) tick();
        total++;
        if (log_q.size() < 5 || log_q[4] !== 32'd4) begin
            bad++;
            $display("FAIL resume_pc: got %0d entries want >=5 with pc 4 fifth",
                     log_q.size());
        end
    endtask

    task automatic test_redirect_drop();
        out_ready = 1'b1;
        enable    = 1'b1;
        lat_lo    = 3;
        lat_hi    = 3;
        do_reset();
        repeat (2) tick();
        #1;
        total++;
        if (imem_req !== 1'b0) begin
            bad++;
            $display("FAIL max_outstanding: req=%b want 0", imem_req);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        redirect_valid = 1'b0;
        log_q.delete();
        repeat (15) tick();
        total++;
        if (log_q.size() < 3 || log_q[0] !== 32'h40) begin
            bad++;
            $display("FAIL redirect_drop: got %0d entries first %h want >=3 first 00000040",
                     log_q.size(), (log_q.size() > 0) ? log_q[0] : 32'hx);
        end
    endtask

    task automatic test_back_to_back();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_pc    = 32'h300;
        tick();
        redirect_valid = 1'b0;
        log_q.delete();
        repeat (20) tick();
        total++;
        if (log_q.size() < 3 || log_q[0] !== 32'h300) begin
            bad++;
            $display("FAIL back_to_back: got %0d entries first %h want >=3 first 00000300",
                     log_q.size(), (log_q.size() > 0) ? log_q[0] : 32'hx);
        end
    endtask

    task automatic test_redirect_collide();
        lat_lo = 1;
        lat_hi = 1;
        do_reset();
        repeat (6) tick();
        #1;
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL collide_pre: valid=%b want 1", out_valid);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL collide_flush: valid=%b want 0", out_valid);
        end
        log_q.delete();
        repeat (8) tick();
        total++;
        if (log_q.size() < 4 || log_q[0] !== 32'h100) begin
            bad++;
            $display("FAIL collide_next: got %0d entries first %h want >=4 first 00000100",
                     log_q.size(), (log_q.size() > 0) ? log_q[0] : 32'hx);
        end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFFFFFF;
        tick();
        redirect_valid = 1'b0;
        log_q.delete();
        repeat (8) tick();
        total++;
        if (log_q.size() < 2 || log_q[0] !== 32'hFFFFFFFF || log_q[1] !== 32'h0) begin
            bad++;
            $display("FAIL pc_wrap: got %0d entries want ffffffff then 00000000",
                     log_q.size());
        end
    endtask

    task automatic test_reset_mid_random();
        int pops;
        out_ready = 1'b0;
        enable    = 1'b1;
        lat_lo    = 1;
        lat_hi    = 2;
        repeat (12) tick();
        #1;
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL prefill: valid=%b want 1", out_valid);
        end
        #1;
        gnt_rand = 1'b1;
        lat_lo   = 1;
        lat_hi   = 4;
        do_reset();
        pops = 0;
        for (int i = 0; i < 600; i++) begin
            out_ready      = ($urandom_range(3, 0) != 0);
            enable         = ($urandom_range(7, 0) != 0);
            redirect_valid = ($urandom_range(24, 0) == 0);
            redirect_pc    = ($urandom_range(1, 0) == 0)
                           ? $urandom()
                           : 32'hFFFFFFFD + 32'($urandom_range(3, 0));
            tick();
            pops = pops + log_q.size();
            log_q.delete();
        end
        redirect_valid = 1'b0;
        enable         = 1'b1;
        out_ready      = 1'b1;
        repeat (30) tick();
        pops = pops + log_q.size();
        total++;
        if (pops < 100) begin
            bad++;
            $display("FAIL random_progress: got %0d pops want >=100", pops);
        end
        enable = 1'b0;
        repeat (20) tick();
        #1;
        total++;
        if (out_valid !== 1'b0 || imem_req !== 1'b0) begin
            bad++;
            $display("FAIL drain_idle: valid=%b req=%b want 0 0", out_valid, imem_req);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drop();
        test_back_to_back();
        test_redirect_collide();
        test_wrap();
        test_reset_mid_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
